// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and the round/shift/clamp helper
package fir_pkg;

  localparam int FIR_IN_W  = 8;
  localparam int FIR_OUT_W = 16;

  // Saturation limits for the default 8-bit decimated output
  localparam int OUT_W_DEF = 8;
  localparam int SAT_HI    = (1 << (OUT_W_DEF - 1)) - 1;
  localparam int SAT_LO    = -(1 << (OUT_W_DEF - 1));

  typedef struct packed {
    logic signed [31:0] value;
    logic               clip;
  } sat_res_t;

  // Largest positive value representable in out_w signed bits
  function automatic logic signed [31:0] sat_hi(input int out_w);
    return (32'sd1 <<< (out_w - 1)) - 32'sd1;
  endfunction

  // Round half up, arithmetic shift right, then clamp to out_w signed bits
  function automatic sat_res_t sat_round(input logic signed [31:0] sum,
                                         input int shift,
                                         input int out_w);
    logic signed [31:0] rnd;
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_res_t           res;
    rnd = (shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0;
    r   = (sum + rnd) >>> shift;
    hi  = sat_hi(out_w);
    lo  = -hi - 32'sd1;
    res.value = r;
    res.clip  = 1'b0;
    if (r > hi) begin
      res.value = hi;
      res.clip  = 1'b1;
    end else if (r < lo) begin
      res.value = lo;
      res.clip  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - first-word fall-through FIFO with count-based full/empty
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  last_head;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle
  assign do_push = push & (~full | do_pop);
  // Keep presenting the last popped word while empty so the output never glitches
  assign head    = empty ? last_head : mem[rd_ptr];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and last-head bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - integrate-and-dump decimator with rounding, saturation and output FIFO
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] Yin,
  input  logic                   in_en,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   sat,
  output logic                   overflow
);

  localparam int PH_W  = $clog2(DECIM);
  localparam int ACC_W = IN_W + PH_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] yin_ext;
  logic signed [ACC_W-1:0] dump_sum;
  logic                    dump_v;
  logic [PH_W-1:0]         phase;
  logic                    last_phase;
  logic signed [31:0]      sum32;
  sat_res_t                rnd_res;
  logic                    unused_hi;
  logic [OUT_W-1:0]        s2_data;
  logic                    s2_v;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  assign yin_ext    = {{PH_W{Yin[IN_W-1]}}, Yin};
  assign acc_next   = acc + yin_ext;
  assign last_phase = (phase == PH_W'(DECIM - 1));
  assign sum32      = {{(32 - ACC_W){dump_sum[ACC_W-1]}}, dump_sum};
  assign rnd_res    = sat_round(sum32, SHIFT, OUT_W);
  assign unused_hi  = ^rnd_res.value[31:OUT_W];

  // Accumulate DECIM enabled samples, then hand the group sum to stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      phase    <= '0;
      dump_sum <= '0;
      dump_v   <= 1'b0;
    end else begin
      dump_v <= 1'b0;
      if (in_en) begin
        if (last_phase) begin
          dump_sum <= acc_next;
          dump_v   <= 1'b1;
          acc      <= '0;
          phase    <= '0;
        end else begin
          acc   <= acc_next;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

  // Register the rounded, clamped dump; sat lines up with the FIFO push it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_data <= '0;
      s2_v    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      s2_v <= dump_v;
      sat  <= dump_v & rnd_res.clip;
      if (dump_v) begin
        s2_data <= rnd_res.value[OUT_W-1:0];
      end
    end
  end

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;

  // A dump arriving at a full FIFO with no pop is lost; remember it until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (s2_v && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_v),
    .push_data (s2_data),
    .pop       (pop),
    .head      (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_fir_decim_out.sv
// tb/tb_fir_decim_out.sv - self-checking bench for fir_decim_out
module tb_fir_decim_out;

  logic               clk;
  logic               rst;
  logic signed [15:0] Yin;
  logic               in_en;
  logic signed [7:0]  m_data;
  logic               m_valid;
  logic               m_ready;
  logic               sat;
  logic               overflow;

  int checks;
  int failures;

  fir_decim_out #(
    .IN_W       (16),
    .OUT_W      (8),
    .DECIM      (4),
    .SHIFT      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Yin      (Yin),
    .in_en    (in_en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .sat      (sat),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: group sums, rounded division, and a bounded queue
  typedef struct {
    int due;
    int val;
    bit clip;
  } item_t;

  item_t pend[$];
  int    fq[$];
  int    grp_sum;
  int    grp_n;
  int    cyc;
  bit    ov_m;
  bit    sat_m;
  bit    live;

  function automatic int round_div4(input int s);
    int r;
    r = s + 2;
    if (r >= 0) return r / 4;
    return -((-r + 3) / 4);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      fq.delete();
      grp_sum = 0;
      grp_n   = 0;
      ov_m    = 1'b0;
      sat_m   = 1'b0;
      live    = 1'b1;
    end else begin
      bit pop_m;
      int size_before;
      size_before = fq.size();
      pop_m = (size_before > 0) && m_ready;
      if (pop_m) void'(fq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (size_before == 4 && !pop_m) ov_m = 1'b1;
        else fq.push_back(pend[0].val);
        void'(pend.pop_front());
      end
      sat_m = 1'b0;
      foreach (pend[i]) if (pend[i].due == cyc + 1 && pend[i].clip) sat_m = 1'b1;
      if (in_en) begin
        grp_sum += int'(Yin);
        grp_n++;
        if (grp_n == 4) begin
          int v;
          bit c;
          v = round_div4(grp_sum);
          c = 1'b0;
          if (v > 127) begin v = 127; c = 1'b1; end
          if (v < -128) begin v = -128; c = 1'b1; end
          pend.push_back('{due: cyc + 2, val: v, clip: c});
          grp_sum = 0;
          grp_n   = 0;
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (live) begin
      chk("m_valid", int'(m_valid), int'(fq.size() > 0));
      if (fq.size() > 0) chk("m_data", int'(m_data), fq[0]);
      chk("sat", int'(sat), int'(sat_m));
      chk("overflow", int'(overflow), int'(ov_m));
    end
  end

  // Record every accepted output word and every sat pulse
  int got[$];
  int sat_cnt;
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got.push_back(int'(m_data));
    if (!rst && sat) sat_cnt++;
  end

  task automatic drive(input bit en, input int y, input bit rdy);
    in_en   = en;
    Yin     = 16'(y);
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 0, rdy);
  endtask

  task automatic check_list(input string name, input int n,
                            input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({name, "_word"}, got[i], e[i]);
    got.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sat_cnt  = 0;
    rst      = 1'b1;
    in_en    = 1'b0;
    Yin      = '0;
    m_ready  = 1'b1;
    idle(2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_sat", int'(sat), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Basic group and two-edge latency
    for (int i = 0; i < 4; i++) drive(1'b1, 100, 1'b1);
    chk("lat_edge_n", int'(m_valid), 0);
    idle(1, 1'b1);
    chk("lat_edge_n1", int'(m_valid), 0);
    idle(1, 1'b1);
    chk("lat_edge_n2_valid", int'(m_valid), 1);
    chk("lat_edge_n2_data", int'(m_data), 100);
    idle(1, 1'b1);
    chk("lat_one_cycle", int'(m_valid), 0);
    idle(2, 1'b1);
    check_list("basic", 1, 100, 0, 0, 0);

    // Negative rounding then small positive
    drive(1'b1, -3, 1'b1); drive(1'b1, -3, 1'b1); drive(1'b1, -3, 1'b1); drive(1'b1, 0, 1'b1);
    drive(1'b1, 1, 1'b1);  drive(1'b1, 1, 1'b1);  drive(1'b1, 1, 1'b1);  drive(1'b1, 0, 1'b1);
    idle(4, 1'b1);
    check_list("round", 2, -2, 1, 0, 0);

    // Saturation both ways
    sat_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1000, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, -1000, 1'b1);
    idle(4, 1'b1);
    check_list("saturate", 2, 127, -128, 0, 0);
    chk("sat_pulses", sat_cnt, 2);

    // Backpressure: five dumps into a four-entry FIFO
    for (int g = 0; g < 5; g++) begin
      drive(1'b1, 10, 1'b0); drive(1'b1, 20, 1'b0);
      drive(1'b1, 30, 1'b0); drive(1'b1, 40, 1'b0);
    end
    idle(3, 1'b0);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_valid", int'(m_valid), 1);
    chk("bp_data", int'(m_data), 25);
    idle(4, 1'b1);
    chk("bp_drained", int'(m_valid), 0);
    chk("bp_overflow_sticky", int'(overflow), 1);
    check_list("drain", 4, 25, 25, 25, 25);

    // Reset mid-group discards the partial sum and clears overflow
    drive(1'b1, 100, 1'b1); drive(1'b1, 100, 1'b1);
    rst = 1'b1;
    drive(1'b0, 0, 1'b1);
    rst = 1'b0;
    chk("rst_overflow_clear", int'(overflow), 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8, 1'b1);
    idle(4, 1'b1);
    check_list("midreset", 1, 8, 0, 0, 0);

    // Strobe gaps: disabled samples are ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4, 1'b1);
      drive(1'b0, 99, 1'b1);
    end
    idle(4, 1'b1);
    check_list("gaps", 1, 4, 0, 0, 0);

    // Mixed traffic with random strobes and ready, checked by the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1200)) - 600,
            1'($urandom_range(0, 2) != 0));
    end
    idle(10, 1'b1);
    chk("final_empty", int'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
